// File: rtl/output_periph_bank.sv
// Memory-mapped LED/HEX/LCD output bank: write/set/clear/toggle stores per byte, optional shadow->active commit.
// Loads return data one cycle after ld_en; accepts one store and one load every cycle, never stalls.
module output_periph_bank #(
  parameter int NUM_CH = 11,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     st_en,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [DATA_W/8-1:0]      byte_en,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     pending_o,
  output logic                     err_o
);
  localparam int NB     = DATA_W / 8;
  localparam int SLOT_W = ADDR_W - 4;

  logic [DATA_W-1:0] r_shadow [NUM_CH];
  logic [DATA_W-1:0] r_active [NUM_CH];
  logic              r_auto;
  logic              r_pending;
  logic              r_err;
  logic [DATA_W-1:0] r_ld_data;
  logic              r_ld_valid;

  logic [SLOT_W-1:0] w_slot;
  logic [1:0]        w_mode;
  logic              w_is_ch, w_is_ctrl, w_is_stat, w_unmapped;
  logic [DATA_W-1:0] w_old, w_new, w_rd;
  logic              w_st_ch, w_ctrl_st, w_commit, w_err_set, w_err_clr;
  logic              w_unused;

  assign w_slot     = addr[ADDR_W-1:4];
  assign w_mode     = addr[3:2];
  assign w_unused   = &{1'b0, addr[1:0]};
  assign w_is_ch    = (w_slot < SLOT_W'(NUM_CH));
  assign w_is_ctrl  = (&w_slot) && (w_mode == 2'b00);
  assign w_is_stat  = (&w_slot) && (w_mode == 2'b01);
  assign w_unmapped = !(w_is_ch || w_is_ctrl || w_is_stat);

  // Shadow of the addressed channel; shared by read-modify-write and load.
  always_comb begin
    w_old = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_slot == SLOT_W'(i)) w_old = r_shadow[i];
    end
  end

  always_comb begin
    w_new = w_old;
    for (int b = 0; b < NB; b++) begin
      if (byte_en[b]) begin
        case (w_mode)
          2'b00:   w_new[b*8 +: 8] = st_data[b*8 +: 8];
          2'b01:   w_new[b*8 +: 8] = w_old[b*8 +: 8] | st_data[b*8 +: 8];
          2'b10:   w_new[b*8 +: 8] = w_old[b*8 +: 8] & ~st_data[b*8 +: 8];
          default: w_new[b*8 +: 8] = w_old[b*8 +: 8] ^ st_data[b*8 +: 8];
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_is_ch)        w_rd = w_old;
    else if (w_is_ctrl) w_rd = {{(DATA_W-2){1'b0}}, r_auto, 1'b0};
    else if (w_is_stat) w_rd = {{(DATA_W-2){1'b0}}, r_pending, r_err};
  end

  assign w_st_ch   = st_en && w_is_ch;
  assign w_ctrl_st = st_en && w_is_ctrl && byte_en[0];
  // Turning auto back on with uncommitted writes publishes them immediately.
  assign w_commit  = w_ctrl_st && (st_data[0] || (st_data[1] && r_pending));
  assign w_err_set = (st_en || ld_en) && w_unmapped;
  assign w_err_clr = st_en && w_is_stat && byte_en[0] && st_data[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_auto     <= 1'b1;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_st_ch && (w_slot == SLOT_W'(i))) begin
          r_shadow[i] <= w_new;
          if (r_auto) r_active[i] <= w_new;
        end else if (w_commit) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_ctrl_st) r_auto <= st_data[1];
      if (w_commit)                r_pending <= 1'b0;
      else if (w_st_ch && !r_auto) r_pending <= 1'b1;
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
      r_ld_valid <= ld_en;
      if (ld_en) r_ld_data <= w_rd;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_data[g*DATA_W +: DATA_W] = r_active[g];
  end

  assign ld_data   = r_ld_data;
  assign ld_valid  = r_ld_valid;
  assign pending_o = r_pending;
  assign err_o     = r_err;
endmodule

// File: tb/tb_output_periph_bank.sv
// Directed table-driven bench for output_periph_bank (NUM_CH=11, DATA_W=32, ADDR_W=8).
module tb_output_periph_bank;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         st_en, ld_en;
  logic [7:0]   addr;
  logic [31:0]  st_data;
  logic [3:0]   byte_en;
  logic [31:0]  ld_data;
  logic         ld_valid;
  logic [351:0] out_data;
  logic         pending_o, err_o;

  int n_vec  = 0;
  int n_miss = 0;

  output_periph_bank #(.NUM_CH(11), .DATA_W(32), .ADDR_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .st_en(st_en), .ld_en(ld_en), .addr(addr),
    .st_data(st_data), .byte_en(byte_en), .ld_data(ld_data), .ld_valid(ld_valid),
    .out_data(out_data), .pending_o(pending_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st;
    logic        ld;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    int          ch;      // channel of out_data to check, -1 for none
    logic [31:0] exp_out;
    logic        chk_ld;
    logic [31:0] exp_ld;
    logic        exp_pend;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic ld, logic [7:0] a, logic [31:0] d, logic [3:0] be,
                              int ch, logic [31:0] eo, logic cl, logic [31:0] el,
                              logic ep, logic ee);
    vec_t v;
    v.st = st; v.ld = ld; v.a = a; v.d = d; v.be = be; v.ch = ch; v.exp_out = eo;
    v.chk_ld = cl; v.exp_ld = el; v.exp_pend = ep; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    st_en = 1'b0; ld_en = 1'b0; addr = 8'h00; st_data = '0; byte_en = 4'h0;
  endtask

  task automatic check_all_zero(int idx);
    for (int c = 0; c < 11; c++) check("out_zero", idx*100 + c, out_data[c*32 +: 32], 32'h0);
  endtask

  initial begin
    idle_inputs();
    // reset overrides a concurrent store
    rst_i = 1'b1; st_en = 1'b1; addr = 8'h10; st_data = 32'hFF; byte_en = 4'hF;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0; idle_inputs();
    n_vec++;
    check_all_zero(0);
    check("rst_pend", 0, {31'b0, pending_o}, 32'h0);
    check("rst_err",  0, {31'b0, err_o}, 32'h0);
    check("rst_vld",  0, {31'b0, ld_valid}, 32'h0);
    check("rst_ld",   0, ld_data, 32'h0);

    //                st    ld    addr   data           be    ch  exp_out        chk  exp_ld        p     e
    tbl.push_back(mk(1'b0, 1'b1, 8'hF0, 32'h0,         4'hF, -1, 32'h0,        1'b1, 32'h2,        1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h10, 32'h0000_00FF, 4'hF,  1, 32'hFF,       1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h10, 32'h0,         4'h0,  1, 32'hFF,       1'b1, 32'hFF,       1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,         4'h0,  1, 32'hFF,       1'b1, 32'hFF,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 32'hF0F0_F0F0, 4'hF,  0, 32'hF0F0_F0F0, 1'b0, 32'h0,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h04, 32'h0000_000F, 4'hF,  0, 32'hF0F0_F0FF, 1'b0, 32'h0,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h08, 32'h0000_00F0, 4'hF,  0, 32'hF0F0_F00F, 1'b0, 32'h0,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h0C, 32'hFFFF_0000, 4'hF,  0, 32'h0F0F_F00F, 1'b0, 32'h0,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 32'h1234_5678, 4'h5,  0, 32'h0F34_F078, 1'b0, 32'h0,       1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h0F34_F078, 1'b0, 1'b0));
    // buffered mode
    tbl.push_back(mk(1'b1, 1'b0, 8'hF0, 32'h0,         4'hF, -1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hF0, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h20, 32'h7E,        4'hF,  2, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h30, 32'h30,        4'hF,  3, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h20, 32'h0,         4'h0,  2, 32'h0,        1'b1, 32'h7E,       1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hF4, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h2,        1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'hF0, 32'h1,         4'hF,  2, 32'h7E,       1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,         4'h0,  3, 32'h30,       1'b0, 32'h0,        1'b0, 1'b0));
    // still buffered after explicit commit; implicit commit when auto returns
    tbl.push_back(mk(1'b1, 1'b0, 8'h40, 32'hAA,        4'hF,  4, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'hF0, 32'h2,         4'hF,  4, 32'hAA,       1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hF0, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h2,        1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h50, 32'h55,        4'hF,  5, 32'h55,       1'b0, 32'h0,        1'b0, 1'b0));
    // error handling
    tbl.push_back(mk(1'b1, 1'b0, 8'hB0, 32'hFFFF_FFFF, 4'hF,  0, 32'h0F34_F078, 1'b0, 32'h0,       1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hF4, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h1,        1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'hF4, 32'h1,         4'hF, -1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hF8, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'hF4, 32'h1,         4'hF, -1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFC, 32'h0,         4'h0, -1, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'hF4, 32'h1,         4'hF, -1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'hE0, 32'h1,         4'hF,  5, 32'h55,       1'b0, 32'h0,        1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 8'hF4, 32'h1,         4'hF, -1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
    // simultaneous store and load: read-old
    tbl.push_back(mk(1'b1, 1'b0, 8'h20, 32'h5,         4'hF,  2, 32'h5,        1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h20, 32'h9,         4'hF,  2, 32'h9,        1'b1, 32'h5,        1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h20, 32'h0,         4'h0,  2, 32'h9,        1'b1, 32'h9,        1'b0, 1'b0));
    // build up a pending write for the reset sequence
    tbl.push_back(mk(1'b1, 1'b0, 8'hF0, 32'h0,         4'hF, -1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h60, 32'h77,        4'hF,  6, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      st_en = tbl[i].st; ld_en = tbl[i].ld; addr = tbl[i].a;
      st_data = tbl[i].d; byte_en = tbl[i].be;
      @(posedge clk_i);
      #1;
      idle_inputs();
      n_vec++;
      if (tbl[i].ch >= 0) check("out_data", i + 1, out_data[tbl[i].ch*32 +: 32], tbl[i].exp_out);
      if (tbl[i].chk_ld) check("ld_data", i + 1, ld_data, tbl[i].exp_ld);
      check("ld_valid", i + 1, {31'b0, ld_valid}, {31'b0, tbl[i].ld});
      check("pending",  i + 1, {31'b0, pending_o}, {31'b0, tbl[i].exp_pend});
      check("err",      i + 1, {31'b0, err_o}, {31'b0, tbl[i].exp_err});
    end

    // reset in the middle of a buffered sequence, with a concurrent load
    rst_i = 1'b1; ld_en = 1'b1; addr = 8'h60;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; idle_inputs();
    n_vec++;
    check_all_zero(90);
    check("mid_rst_pend", 90, {31'b0, pending_o}, 32'h0);
    check("mid_rst_vld",  90, {31'b0, ld_valid}, 32'h0);
    check("mid_rst_ld",   90, ld_data, 32'h0);

    ld_en = 1'b1; addr = 8'hF0;
    @(posedge clk_i);
    #1;
    idle_inputs();
    n_vec++;
    check("mid_rst_ctrl", 91, ld_data, 32'h2);
    check("mid_rst_ctrl_vld", 91, {31'b0, ld_valid}, 32'h1);

    ld_en = 1'b1; addr = 8'h60;
    @(posedge clk_i);
    #1;
    idle_inputs();
    n_vec++;
    check("mid_rst_shadow", 92, ld_data, 32'h0);

    // after reset, auto mode: a store lands on out_data directly
    st_en = 1'b1; addr = 8'h60; st_data = 32'h3C; byte_en = 4'h1;
    @(posedge clk_i);
    #1;
    idle_inputs();
    n_vec++;
    check("post_rst_auto", 93, out_data[6*32 +: 32], 32'h3C);
    check("post_rst_pend", 93, {31'b0, pending_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
